// File: rtl/ms_jk_reg_bank.sv
// ms_jk_reg_bank: a bank of WIDTH master/slave flip-flops.
// The master stage evaluates JK, D, T or SR behaviour per bit. The slave stage
// copies the master on every edge, so the architectural output q trails the
// master by one edge. Status flags report an illegal SR input and changes in q.
module ms_jk_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             err_clr,
  output logic [WIDTH-1:0] qm,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sr_err,
  output logic             sr_err_sticky,
  output logic             q_chg
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] qm_next;
  logic             sr_illegal;

  assign mode_sel = mode_e'(mode);

  // Complement output is purely combinational from the slave.
  assign q_bar = ~q;

  // Master next-state: per-bit JK / D / T / SR evaluation from the current qm.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    qm_next    = qm;
    sr_illegal = 1'b0;
    if (en) begin
      case (mode_sel)
        // 00 hold, 01 clear, 10 set, 11 toggle
        MODE_JK: qm_next = (j & ~qm) | (~k & qm);
        MODE_D:  qm_next = j;
        MODE_T:  qm_next = qm ^ j;
        // S=R=1 bits hold; the remaining bits still set or clear.
        MODE_SR: begin
          qm_next    = (qm | (j & ~k)) & ~(k & ~j);
          sr_illegal = |(j & k);
        end
        default: qm_next = qm;
      endcase
    end
  end

  // Master and slave registers: the slave takes the pre-edge master value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make q sample the old qm, which is what
      // gives the master/slave one-edge separation.
      qm <= qm_next;
      q  <= qm;
    end
  end

  // Status flags: SR error pulse and sticky, plus the q-changed pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_err        <= 1'b0;
      sr_err_sticky <= 1'b0;
      q_chg         <= 1'b0;
    end else begin
      sr_err <= sr_illegal;
      q_chg  <= (qm != q);
      // A new error on the same edge as a clear request must stay visible.
      if (sr_illegal) begin
        sr_err_sticky <= 1'b1;
      end else if (err_clr) begin
        sr_err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ms_jk_reg_bank.sv
// Directed bench for ms_jk_reg_bank with WIDTH=4, RESET_VAL=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_ms_jk_reg_bank;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         err_clr;
  logic [W-1:0] qm;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         sr_err;
  logic         sr_err_sticky;
  logic         q_chg;

  int checks = 0;
  int errors = 0;

  ms_jk_reg_bank #(
    .WIDTH    (W),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .j            (j),
    .k            (k),
    .err_clr      (err_clr),
    .qm           (qm),
    .q            (q),
    .q_bar        (q_bar),
    .sr_err       (sr_err),
    .sr_err_sticky(sr_err_sticky),
    .q_chg        (q_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; err_clr = 1'b0;
    #3;
    checks++; if (qm !== 4'b0000) begin errors++; $display("FAIL rst_qm: got %b want 0000", qm); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL rst_q: got %b want 0000", q); end
    checks++; if (q_bar !== 4'b1111) begin errors++; $display("FAIL rst_qbar: got %b want 1111", q_bar); end
    checks++; if ({sr_err, sr_err_sticky, q_chg} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {sr_err, sr_err_sticky, q_chg}); end
    step();
    step();
    #3 rst = 1'b0;
    step();
    // First edge after release is a normal edge with no change in q.
    checks++; if (q_chg !== 1'b0) begin errors++; $display("FAIL rst_release_qchg: got %b want 0", q_chg); end
  endtask

  task automatic test_jk();
    mode = 2'b00; en = 1'b1; j = 4'b0011; k = 4'b0101;
    step();
    checks++; if (qm !== 4'b0011) begin errors++; $display("FAIL jk_qm_e1: got %b want 0011", qm); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL jk_q_e1: got %b want 0000", q); end
    en = 1'b0;
    step();
    checks++; if (q !== 4'b0011) begin errors++; $display("FAIL jk_q_e2: got %b want 0011", q); end
    checks++; if (q_chg !== 1'b1) begin errors++; $display("FAIL jk_qchg_e2: got %b want 1", q_chg); end
    checks++; if (q_bar !== 4'b1100) begin errors++; $display("FAIL jk_qbar_e2: got %b want 1100", q_bar); end
  endtask

  task automatic test_sr();
    // qm = 0011 here. bit0 S=R=1 holds, bit2 sets.
    mode = 2'b11; en = 1'b1; j = 4'b0101; k = 4'b0001;
    step();
    checks++; if (qm !== 4'b0111) begin errors++; $display("FAIL sr_qm: got %b want 0111", qm); end
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_err_pulse: got %b want 1", sr_err); end
    checks++; if (sr_err_sticky !== 1'b1) begin errors++; $display("FAIL sr_sticky_set: got %b want 1", sr_err_sticky); end
    en = 1'b0;
    step();
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL sr_err_end: got %b want 0", sr_err); end
    checks++; if (sr_err_sticky !== 1'b1) begin errors++; $display("FAIL sr_sticky_hold: got %b want 1", sr_err_sticky); end
    checks++; if (q !== 4'b0111 || q_chg !== 1'b1) begin
      errors++; $display("FAIL sr_q: got q=%b chg=%b want q=0111 chg=1", q, q_chg); end
    err_clr = 1'b1;
    step();
    checks++; if (sr_err_sticky !== 1'b0) begin errors++; $display("FAIL sr_sticky_clr: got %b want 0", sr_err_sticky); end
    // Clear coincident with a new illegal input: set wins.
    en = 1'b1; j = 4'b0001; k = 4'b0001;
    step();
    checks++; if (sr_err_sticky !== 1'b1) begin errors++; $display("FAIL sr_set_wins: got %b want 1", sr_err_sticky); end
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_err_pulse2: got %b want 1", sr_err); end
    checks++; if (qm !== 4'b0111) begin errors++; $display("FAIL sr_qm_hold: got %b want 0111", qm); end
    en = 1'b0;
    step();
    checks++; if ({sr_err, sr_err_sticky} !== 2'b00) begin
      errors++; $display("FAIL sr_final_clr: got %b want 00", {sr_err, sr_err_sticky}); end
    err_clr = 1'b0;
  endtask

  task automatic test_enable();
    // Load qm=0110 via D mode (q still 0111 afterwards).
    mode = 2'b01; en = 1'b1; j = 4'b0110;
    step();
    checks++; if (qm !== 4'b0110) begin errors++; $display("FAIL en_load: got %b want 0110", qm); end
    en = 1'b0;
    for (int e = 0; e < 5; e++) begin
      j = 4'($urandom); k = 4'($urandom); mode = 2'($urandom);
      step();
      checks++; if (qm !== 4'b0110) begin errors++; $display("FAIL en_qm_hold[%0d]: got %b want 0110", e, qm); end
      checks++; if (q !== 4'b0110) begin errors++; $display("FAIL en_q[%0d]: got %b want 0110", e, q); end
      checks++; if (q_chg !== (e == 0)) begin
        errors++; $display("FAIL en_qchg[%0d]: got %b want %b", e, q_chg, (e == 0)); end
      checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL en_sr_err[%0d]: got %b want 0", e, sr_err); end
    end
  endtask

  task automatic test_t_mode();
    logic [W-1:0] exp_qm [3];
    logic [W-1:0] exp_q  [3];
    exp_qm = '{4'b1111, 4'b0000, 4'b1111};
    exp_q  = '{4'b0000, 4'b1111, 4'b0000};
    rst = 1'b1; en = 1'b0;
    #3 rst = 1'b0;
    mode = 2'b10; en = 1'b1; j = 4'b1111; k = 4'b0000;
    for (int e = 0; e < 3; e++) begin
      step();
      checks++; if (qm !== exp_qm[e]) begin errors++; $display("FAIL t_qm[%0d]: got %b want %b", e, qm, exp_qm[e]); end
      checks++; if (q !== exp_q[e]) begin errors++; $display("FAIL t_q[%0d]: got %b want %b", e, q, exp_q[e]); end
    end
  endtask

  task automatic test_d_reset();
    // Mode change from T to D takes effect on the first edge it is sampled.
    mode = 2'b01; en = 1'b1; j = 4'b1010;
    step();
    checks++; if (qm !== 4'b1010) begin errors++; $display("FAIL d_qm: got %b want 1010", qm); end
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (qm !== 4'b0000 || q !== 4'b0000) begin
      errors++; $display("FAIL dr_async: got qm=%b q=%b want 0000 0000", qm, q); end
    checks++; if (q_bar !== 4'b1111 || {sr_err, sr_err_sticky, q_chg} !== 3'b000) begin
      errors++; $display("FAIL dr_async_flags: got qbar=%b flags=%b want 1111 000", q_bar, {sr_err, sr_err_sticky, q_chg}); end
    #1 rst = 1'b0;
    step();
    checks++; if (q !== 4'b0000 || q_chg !== 1'b0) begin
      errors++; $display("FAIL dr_release: got q=%b chg=%b want 0000 0", q, q_chg); end
    en = 1'b1; j = 4'b0101;
    step();
    checks++; if (qm !== 4'b0101 || q !== 4'b0000) begin
      errors++; $display("FAIL dr_d_e1: got qm=%b q=%b want 0101 0000", qm, q); end
    en = 1'b0;
    step();
    checks++; if (q !== 4'b0101 || q_chg !== 1'b1) begin
      errors++; $display("FAIL dr_d_e2: got q=%b chg=%b want 0101 1", q, q_chg); end
    checks++; if (q_bar !== 4'b1010) begin errors++; $display("FAIL dr_qbar: got %b want 1010", q_bar); end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_sr();
    test_enable();
    test_t_mode();
    test_d_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_jk_reg_bank.md
MS_JK_REG_BANK -- requirements
Module: ms_jk_reg_bank

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits (legal 1..64).
REQ-002 The block SHALL have parameter RESET_VAL, default all zeros, WIDTH bits, giving the master and slave reset value.

Interface
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  master update enable; 0 = master holds.
REQ-006 mode  input  2  00 JK, 01 D, 10 T, 11 SR.
REQ-007 j  input  WIDTH  J / D / T / S per bit, depending on mode.
REQ-008 k  input  WIDTH  K / R per bit; ignored in D and T modes.
REQ-009 err_clr  input  1  clears sr_err_sticky.
REQ-010 qm  output  WIDTH  master stage state.
REQ-011 q  output  WIDTH  slave stage state, the architectural output.
REQ-012 q_bar  output  WIDTH  always ~q, combinational.
REQ-013 sr_err  output  1  one-cycle pulse flagging an illegal SR input.
REQ-014 sr_err_sticky  output  1  latched SR error.
REQ-015 q_chg  output  1  one-cycle pulse flagging that q changed value.

Function
REQ-016 On each rising clk edge with en=1, the master SHALL update per bit i from the current qm[i], as follows.
- JK: j,k = 00 holds, 01 clears, 10 sets, 11 toggles.
- D: qm[i] <= j[i].
- T: j[i]=1 toggles and j[i]=0 holds.
- SR: S=j, R=k; 00 holds, 01 clears, 10 sets, 11 holds (illegal).
REQ-017 On each rising clk edge with en=0, qm SHALL hold regardless of mode, j and k.
REQ-018 On every rising clk edge, q SHALL load the pre-edge value of qm, independent of en. Input-to-q latency is therefore two edges and input-to-qm latency is one edge.
REQ-019 The master and slave SHALL update on the same edge, and q SHALL never see a qm value updated in that same edge.
REQ-020 sr_err SHALL be 1 for exactly the cycle following an edge on which en=1, mode=11 and (j & k) != 0.
- It is 0 at all other times.
- Illegal bits hold; legal bits in the same vector still update.
REQ-021 sr_err_sticky SHALL set on the same edge that sets sr_err, and SHALL clear on an edge with err_clr=1.
REQ-022 When a set condition and err_clr=1 occur on the same edge, the set SHALL win and sr_err_sticky = 1.
REQ-023 q_chg SHALL be 1 for the cycle following any edge on which the q value loaded differs from the previous q; otherwise 0.
REQ-024 A mode change SHALL take effect on the first edge at which the new mode is sampled, with no extra latency and no hidden state.
REQ-025 All outputs SHALL be free of X after reset, for any legal parameter values.

Reset
REQ-026 While rst=1, the block SHALL hold the following values, asynchronously and without waiting for a clk edge.
- qm = RESET_VAL, q = RESET_VAL, q_bar = ~RESET_VAL.
- sr_err = 0, sr_err_sticky = 0, q_chg = 0.
REQ-027 rst asserted mid-operation SHALL abort any pending master-to-slave transfer; the first edge after release SHALL load q with RESET_VAL.
REQ-028 The first edge after rst falls SHALL behave as a normal edge, with no q_chg pulse caused by reset itself.

Verification (WIDTH=4, RESET_VAL=0)
REQ-029 Reset then JK operation SHALL be checked as follows.
- Stimulus: rst pulse, then mode=00, en=1, j=0011, k=0101 for one edge.
- Required: qm=0011 after edge 1; q=0011 and q_chg=1 after edge 2; q_bar=1100.
REQ-030 T mode SHALL be checked as follows.
- Stimulus: from reset, mode=10, j=1111 for three edges.
- Required: qm = 1111, 0000, 1111; q = 0000, 1111, 0000 (one-edge lag).
REQ-031 The SR illegal input SHALL be checked as follows.
- Stimulus: from qm=0011, mode=11, j=0101, k=0001 for one edge.
- Required: qm=0111 (bit0 held); sr_err pulses for one cycle; sr_err_sticky stays 1 until an err_clr edge.
- Also: err_clr coincident with a new illegal input keeps sr_err_sticky=1.
REQ-032 Enable hold SHALL be checked as follows.
- Stimulus: after qm=0110, set en=0 and toggle j, k and mode randomly for 5 edges.
- Required: qm stays 0110; q=0110 after the first edge; q_chg pulses once, then stays 0.
REQ-033 D mode with a mid-operation reset SHALL be checked as follows.
- Stimulus: mode=01, j=1010 for one edge, then rst asserted between edges.
- Required: qm, q and flags return to reset values immediately; the edge after release gives q=0000.
- Then j=0101 gives qm=0101 one edge later and q=0101 two edges later.
